// File: rtl/skid_buffer.sv
// -----------------------------------------------------------------------------
// skid_buffer
//   Registered valid/ready pipeline slice. Forward data/valid and backward ready
//   all come straight from flops, so no input reaches any output combinationally.
//   A main register feeds the output and a skid register catches the word in
//   flight when downstream stalls. This sustains one word per cycle.
//
// Parameters
//   DATA_WIDTH       payload width in bits
//   STALL_CNT_WIDTH  stall counter width (used only with SKID_BUFFER_STATS_EN)
//
// Ports
//   clk_i          in   rising-edge clock
//   reset_i        in   asynchronous, active-high reset
//   s_valid_i      in   upstream word valid
//   s_ready_o      out  upstream may transfer (registered)
//   s_data_i       in   upstream payload
//   m_valid_o      out  downstream word valid (registered)
//   m_ready_i      in   downstream accepts
//   m_data_o       out  downstream payload (registered)
//   stall_count_o  out  saturating count of stalled output cycles
//                       (present only when SKID_BUFFER_STATS_EN is defined)
//
// Build option
//   SKID_BUFFER_STATS_EN : adds stall_count_o and its counter. The datapath is
//                          identical with or without it.
// -----------------------------------------------------------------------------
module skid_buffer #(
   parameter int unsigned DATA_WIDTH      = 32,
   parameter int unsigned STALL_CNT_WIDTH = 16
) (
   input  logic                       clk_i,
   input  logic                       reset_i,
   input  logic                       s_valid_i,
   output logic                       s_ready_o,
   input  logic [DATA_WIDTH-1:0]      s_data_i,
   output logic                       m_valid_o,
   input  logic                       m_ready_i,
   output logic [DATA_WIDTH-1:0]      m_data_o
`ifdef SKID_BUFFER_STATS_EN
   ,
   output logic [STALL_CNT_WIDTH-1:0] stall_count_o
`endif
);

   localparam logic [1:0] ST_EMPTY = 2'd0;  // main and skid empty
   localparam logic [1:0] ST_BUSY  = 2'd1;  // main full, skid empty
   localparam logic [1:0] ST_FULL  = 2'd2;  // main and skid full

   logic [1:0]            r_state;
   logic [1:0]            w_state_nxt;
   logic [DATA_WIDTH-1:0] r_main;
   logic [DATA_WIDTH-1:0] w_main_nxt;
   logic [DATA_WIDTH-1:0] r_skid;
   logic [DATA_WIDTH-1:0] w_skid_nxt;
   logic                  r_m_valid;
   logic                  r_s_ready;
   logic                  w_in;
   logic                  w_out;

   assign w_in  = s_valid_i & r_s_ready;
   assign w_out = r_m_valid & m_ready_i;

   always_comb begin
      w_state_nxt = r_state;
      w_main_nxt  = r_main;
      w_skid_nxt  = r_skid;
      case (r_state)
         ST_EMPTY: begin
            if (w_in) begin
               w_main_nxt  = s_data_i;
               w_state_nxt = ST_BUSY;
            end
         end
         ST_BUSY: begin
            if (w_in && w_out) begin
               w_main_nxt = s_data_i;
            end else if (w_in) begin
               // Downstream stalled: park the in-flight word in the skid register.
               w_skid_nxt  = s_data_i;
               w_state_nxt = ST_FULL;
            end else if (w_out) begin
               w_state_nxt = ST_EMPTY;
            end
         end
         ST_FULL: begin
            if (w_out) begin
               w_main_nxt  = r_skid;
               w_state_nxt = ST_BUSY;
            end
         end
         default: begin
            w_state_nxt = ST_EMPTY;
         end
      endcase
   end

   // Output flags are derived from the next state and registered. s_ready_o
   // therefore stays low in reset and rises on the first edge after release.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         r_state   <= ST_EMPTY;
         r_main    <= '0;
         r_skid    <= '0;
         r_m_valid <= 1'b0;
         r_s_ready <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_main    <= w_main_nxt;
         r_skid    <= w_skid_nxt;
         r_m_valid <= (w_state_nxt != ST_EMPTY);
         r_s_ready <= (w_state_nxt != ST_FULL);
      end
   end

   assign s_ready_o = r_s_ready;
   assign m_valid_o = r_m_valid;
   assign m_data_o  = r_main;

`ifdef SKID_BUFFER_STATS_EN
   logic [STALL_CNT_WIDTH-1:0] r_stall_cnt;

   // Saturating count of cycles where a word is presented but not taken.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         r_stall_cnt <= '0;
      end else if (r_m_valid && !m_ready_i && (r_stall_cnt != '1)) begin
         r_stall_cnt <= r_stall_cnt + STALL_CNT_WIDTH'(1);
      end
   end

   assign stall_count_o = r_stall_cnt;
`endif

endmodule

// File: tb/tb_skid_buffer.sv
// -----------------------------------------------------------------------------
// tb_skid_buffer
//   Self-checking bench for skid_buffer. A queue-based reference model holds
//   the words in flight, and a negedge compare process checks every cycle.
//   Directed sequences add literal expectations for reset, streaming, skid,
//   reset-while-full and (with SKID_BUFFER_STATS_EN) stall-counter saturation.
// -----------------------------------------------------------------------------
module tb_skid_buffer;

   localparam int unsigned DW = 32;
`ifdef SKID_BUFFER_STATS_EN
   localparam int unsigned SW = 4;
`else
   localparam int unsigned SW = 16;
`endif

   logic          clk     = 1'b0;
   logic          rst     = 1'b1;
   logic          s_valid = 1'b0;
   logic          m_ready = 1'b0;
   logic [DW-1:0] s_data  = '0;
   logic          s_ready;
   logic          m_valid;
   logic [DW-1:0] m_data;
`ifdef SKID_BUFFER_STATS_EN
   logic [SW-1:0] stall_count;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   skid_buffer #(
      .DATA_WIDTH      (DW),
      .STALL_CNT_WIDTH (SW)
   ) u_dut (
      .clk_i     (clk),
      .reset_i   (rst),
      .s_valid_i (s_valid),
      .s_ready_o (s_ready),
      .s_data_i  (s_data),
      .m_valid_o (m_valid),
      .m_ready_i (m_ready),
      .m_data_o  (m_data)
`ifdef SKID_BUFFER_STATS_EN
      ,
      .stall_count_o (stall_count)
`endif
   );

   task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: a FIFO of at most two words. Ready comes back one edge
   // after reset release and is withheld while two words are held.
   logic [DW-1:0] q[$];
   bit            ready_ok = 1'b0;
   int unsigned   n_push   = 0;
   int unsigned   m_stall  = 0;
   int unsigned   dut_pops = 0;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         q.delete();
         ready_ok = 1'b0;
         m_stall  = 0;
      end else begin
         bit pop;
         bit push;
         pop  = (q.size() > 0) && m_ready;
         push = s_valid && ready_ok && (q.size() < 2);
         if ((q.size() > 0) && !m_ready && (m_stall < ((1 << SW) - 1))) m_stall++;
         if (pop) void'(q.pop_front());
         if (push) begin
            q.push_back(s_data);
            n_push++;
         end
         ready_ok = 1'b1;
      end
   end

   // Words actually handed off by the DUT, counted independently of the model.
   always @(posedge clk) begin
      if (!rst && m_valid && m_ready) dut_pops++;
   end

   // Per-cycle compare against the model, plus a stall-stability check.
   logic          prev_valid = 1'b0;
   logic          prev_rst   = 1'b1;
   logic [DW-1:0] prev_data  = '0;

   always @(negedge clk) begin
      chk("m_valid", m_valid, (q.size() > 0));
      chk("s_ready", s_ready, (ready_ok && (q.size() < 2)));
      if (q.size() > 0) chk("m_data", m_data, q[0]);
      if (!rst && !prev_rst && prev_valid && !m_ready) begin
         chk("stall_hold_valid", m_valid, 1);
         chk("stall_hold_data", m_data, prev_data);
      end
`ifdef SKID_BUFFER_STATS_EN
      chk("stall_count", stall_count, m_stall);
`endif
      prev_valid = m_valid;
      prev_data  = m_data;
      prev_rst   = rst;
   end

   // Advance one full cycle; inputs change and directed checks sample at negedge+1.
   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   initial begin
      int unsigned cyc;
      int unsigned base_push;
      int unsigned base_pops;

      // Reset values and release timing.
      repeat (3) tick();
      chk("rst_m_valid", m_valid, 0);
      chk("rst_m_data", m_data, 0);
      chk("rst_s_ready", s_ready, 0);
`ifdef SKID_BUFFER_STATS_EN
      chk("rst_stall_count", stall_count, 0);
`endif
      rst = 1'b0;
      #1;
      chk("release_s_ready_low", s_ready, 0);
      tick();
      chk("release_s_ready_high", s_ready, 1);

      // Back-to-back streaming 1..8 with one-cycle latency.
      m_ready = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         s_valid = 1'b1;
         s_data  = DW'(i);
         tick();
         chk("stream_data", m_data, DW'(i));
         chk("stream_valid", m_valid, 1);
         chk("stream_ready", s_ready, 1);
      end
      s_valid = 1'b0;
      tick();
      chk("stream_drained", m_valid, 0);

      // Skid: 0xA in main, 0xB arrives while downstream stalls.
      m_ready = 1'b0;
      s_valid = 1'b1;
      s_data  = 'hA;
      tick();
      chk("skid_busy_data", m_data, 'hA);
      chk("skid_busy_ready", s_ready, 1);
      s_data = 'hB;
      tick();
      chk("skid_full_ready", s_ready, 0);
      chk("skid_full_data", m_data, 'hA);
      s_valid = 1'b0;
      s_data  = 'hDEAD;
      tick();
      chk("skid_held_data", m_data, 'hA);
      chk("skid_held_valid", m_valid, 1);
      m_ready = 1'b1;
      tick();
      chk("skid_pop_data", m_data, 'hB);
      chk("skid_pop_ready", s_ready, 1);
      tick();
      chk("skid_empty", m_valid, 0);

      // Random valid/ready, 10k accepted words.
      base_push = n_push;
      base_pops = dut_pops;
      cyc = 0;
      while ((n_push - base_push < 10000) && (cyc < 60000)) begin
         s_valid = 1'($urandom_range(0, 1));
         s_data  = $urandom;
         m_ready = 1'($urandom_range(0, 1));
         tick();
         cyc++;
      end
      chk("random_budget", (cyc < 60000), 1);
      s_valid = 1'b0;
      m_ready = 1'b1;
      repeat (4) tick();
      chk("random_no_loss", dut_pops - base_pops, n_push - base_push);
      chk("random_drained", m_valid, 0);

      // Reset while FULL: 0xA and 0xB must be discarded.
      m_ready = 1'b0;
      s_valid = 1'b1;
      s_data  = 'hA;
      tick();
      s_data = 'hB;
      tick();
      s_valid = 1'b0;
      chk("full_before_reset", s_ready, 0);
      #2;
      rst = 1'b1;
      #1;
      chk("midrst_m_valid", m_valid, 0);
      chk("midrst_m_data", m_data, 0);
      chk("midrst_s_ready", s_ready, 0);
      tick();
      rst = 1'b0;
      tick();
      chk("postrst_ready", s_ready, 1);
      chk("postrst_empty", m_valid, 0);
      m_ready = 1'b1;
      s_valid = 1'b1;
      s_data  = 'hC;
      tick();
      s_valid = 1'b0;
      chk("postrst_c_data", m_data, 'hC);
      chk("postrst_c_valid", m_valid, 1);
      tick();
      chk("postrst_c_alone", m_valid, 0);

`ifdef SKID_BUFFER_STATS_EN
      // Stall counter saturation, then clear on reset.
      rst = 1'b1;
      tick();
      rst = 1'b0;
      tick();
      chk("stats_cleared", stall_count, 0);
      m_ready = 1'b0;
      s_valid = 1'b1;
      s_data  = 'h5;
      tick();
      s_valid = 1'b0;
      repeat (20) tick();
      chk("stats_saturated", stall_count, 15);
      rst = 1'b1;
      #1;
      chk("stats_reset", stall_count, 0);
      tick();
      rst = 1'b0;
      tick();
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
